// File: rtl/ysyx_220066_alu_issue_if.sv
// Issue-stage bundle: decoded-stage input side and the EX-stage ALU operand side.
interface ysyx_220066_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [4:0]  out_aluctr;
  logic [63:0] out_pc;
  logic        out_illegal;

  modport master (
    input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_a, out_b, out_aluctr, out_pc, out_illegal
  );

  modport slave (
    output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_aluctr, out_pc, out_illegal
  );
endinterface

// File: rtl/ysyx_220066_alu_issue.sv
// RV64I ALU issue stage: decodes operands/aluctr and holds them in a two-entry
// (main + skid) slot so that in_ready can come straight from a flop.
//
// state | meaning
// EMPTY | no entry held
// ONE   | main entry valid, presented on out_*
// FULL  | main and skid valid, input held off
module ysyx_220066_alu_issue (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  ysyx_220066_alu_issue_if.master       bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [4:0]  ctr;
    logic        ill;
  } slot_t;

  state_t state_q, state_d;
  slot_t  main_q, skid_q, dec;
  logic   in_ready_q;
  logic   load_main, load_skid, skid_to_main;
  logic   in_fire, out_fire;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_u;
  logic        legal;

  assign opcode = bus.in_inst[6:0];
  assign f3     = bus.in_inst[14:12];
  assign f7     = bus.in_inst[31:25];
  assign imm_i  = {{52{bus.in_inst[31]}}, bus.in_inst[31:20]};
  assign imm_s  = {{52{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
  assign imm_u  = {{32{bus.in_inst[31]}}, bus.in_inst[31:12], 12'h000};

  // funct3 011 is the unsigned compare, not pass-B
  function automatic logic [3:0] f3_op(input logic [2:0] f);
    return (f == 3'b011) ? 4'b1010 : {1'b0, f};
  endfunction

  always_comb begin
    dec     = '0;
    dec.pc  = bus.in_pc;
    legal   = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.a = bus.in_rs1;
        dec.b = bus.in_rs2;
        if (f7 == 7'b0000000) begin
          legal   = 1'b1;
          dec.ctr = {1'b0, f3_op(f3)};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal   = 1'b1;
          dec.ctr = {2'b01, f3};
        end
      end
      7'b0111011: begin
        dec.a = bus.in_rs1;
        dec.b = bus.in_rs2;
        if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) begin
          legal   = 1'b1;
          dec.ctr = {2'b10, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal   = 1'b1;
          dec.ctr = {2'b11, f3};
        end
      end
      7'b0010011: begin
        dec.a = bus.in_rs1;
        dec.b = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.b = {58'd0, bus.in_inst[25:20]};
          if (bus.in_inst[31:26] == 6'b000000) begin
            legal   = 1'b1;
            dec.ctr = {2'b00, f3};
          end else if (f3 == 3'b101 && bus.in_inst[31:26] == 6'b010000) begin
            legal   = 1'b1;
            dec.ctr = 5'b01101;
          end
        end else begin
          legal   = 1'b1;
          dec.ctr = {1'b0, f3_op(f3)};
        end
      end
      7'b0011011: begin
        dec.a = bus.in_rs1;
        if (f3 == 3'b000) begin
          legal   = 1'b1;
          dec.b   = imm_i;
          dec.ctr = 5'b10000;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.b = {59'd0, bus.in_inst[24:20]};
          if (f7 == 7'b0000000) begin
            legal   = 1'b1;
            dec.ctr = {2'b10, f3};
          end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
            legal   = 1'b1;
            dec.ctr = 5'b11101;
          end
        end
      end
      7'b0110111: begin
        legal   = 1'b1;
        dec.b   = imm_u;
        dec.ctr = 5'b00011;
      end
      7'b0010111: begin
        legal = 1'b1;
        dec.a = bus.in_pc;
        dec.b = imm_u;
      end
      7'b1101111: begin
        legal = 1'b1;
        dec.a = bus.in_pc;
        dec.b = 64'd4;
      end
      7'b1100111: begin
        legal = (f3 == 3'b000);
        dec.a = bus.in_pc;
        dec.b = 64'd4;
      end
      7'b0000011: begin
        legal = (f3 != 3'b111);
        dec.a = bus.in_rs1;
        dec.b = imm_i;
      end
      7'b0100011: begin
        legal = (f3[2] == 1'b0);
        dec.a = bus.in_rs1;
        dec.b = imm_s;
      end
      7'b1100011: begin
        dec.a = bus.in_rs1;
        dec.b = bus.in_rs2;
        legal = (f3[2:1] != 2'b01);
        case (f3[2:1])
          2'b00:   dec.ctr = 5'b01000;
          2'b10:   dec.ctr = 5'b00010;
          default: dec.ctr = 5'b01010;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // illegal bundles still flow, but with neutral operands
    if (!legal) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.ctr = '0;
    end
    dec.ill = ~legal;
  end

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_main)         main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= dec;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_a       = main_q.a;
  assign bus.out_b       = main_q.b;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_aluctr  = main_q.ctr;
  assign bus.out_illegal = main_q.ill;
endmodule

// File: tb/tb_ysyx_220066_alu_issue.sv
// Bench for the ALU issue stage: queue-based reference model plus literal spot checks.
module tb_ysyx_220066_alu_issue;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  ysyx_220066_alu_issue_if bus ();

  ysyx_220066_alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b01000, C_SLL = 5'b00001,
    C_SLT = 5'b00010, C_SLTU = 5'b01010, C_PASSB = 5'b00011, C_XOR = 5'b00100,
    C_SRL = 5'b00101, C_SRA = 5'b01101, C_OR = 5'b00110, C_AND = 5'b00111,
    C_ADDW = 5'b10000, C_SUBW = 5'b11000, C_SLLW = 5'b10001, C_SRLW = 5'b10101,
    C_SRAW = 5'b11101;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [4:0]  ctr;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decode written per mnemonic.
  function automatic ent_t model(input logic [31:0] i, input logic [63:0] pc,
                                 input logic [63:0] r1, input logic [63:0] r2);
    ent_t e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] immi, imms, immu;
    f3   = i[14:12];
    f7   = i[31:25];
    immi = 64'($signed(i[31:20]));
    imms = 64'($signed({i[31:25], i[11:7]}));
    immu = 64'($signed({i[31:12], 12'h000}));
    e = '0;
    e.pc  = pc;
    e.ill = 1'b1;
    case (i[6:0])
      7'b0110011: begin
        e.a = r1; e.b = r2;
        if (f7 == 7'h00) begin
          e.ill = 1'b0;
          case (f3)
            3'd0: e.ctr = C_ADD;  3'd1: e.ctr = C_SLL; 3'd2: e.ctr = C_SLT; 3'd3: e.ctr = C_SLTU;
            3'd4: e.ctr = C_XOR;  3'd5: e.ctr = C_SRL; 3'd6: e.ctr = C_OR;  default: e.ctr = C_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 1'b0; e.ctr = C_SUB; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.ctr = C_SRA; end
      end
      7'b0111011: begin
        e.a = r1; e.b = r2;
        if (f7 == 7'h00 && f3 == 3'd0) begin e.ill = 1'b0; e.ctr = C_ADDW; end
        if (f7 == 7'h00 && f3 == 3'd1) begin e.ill = 1'b0; e.ctr = C_SLLW; end
        if (f7 == 7'h00 && f3 == 3'd5) begin e.ill = 1'b0; e.ctr = C_SRLW; end
        if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 1'b0; e.ctr = C_SUBW; end
        if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.ctr = C_SRAW; end
      end
      7'b0010011: begin
        e.a = r1; e.b = immi; e.ill = 1'b0;
        case (f3)
          3'd0: e.ctr = C_ADD; 3'd2: e.ctr = C_SLT; 3'd3: e.ctr = C_SLTU; 3'd4: e.ctr = C_XOR;
          3'd6: e.ctr = C_OR;  3'd7: e.ctr = C_AND;
          3'd1: begin e.b = i[25:20]; e.ctr = C_SLL; e.ill = (i[31:26] != 6'd0); end
          default: begin
            e.b = i[25:20];
            if (i[31:26] == 6'd0) e.ctr = C_SRL;
            else if (i[31:26] == 6'b010000) e.ctr = C_SRA;
            else e.ill = 1'b1;
          end
        endcase
      end
      7'b0011011: begin
        e.a = r1;
        if (f3 == 3'd0) begin e.ill = 1'b0; e.b = immi; e.ctr = C_ADDW; end
        if (f3 == 3'd1 && f7 == 7'h00) begin e.ill = 1'b0; e.b = i[24:20]; e.ctr = C_SLLW; end
        if (f3 == 3'd5 && f7 == 7'h00) begin e.ill = 1'b0; e.b = i[24:20]; e.ctr = C_SRLW; end
        if (f3 == 3'd5 && f7 == 7'h20) begin e.ill = 1'b0; e.b = i[24:20]; e.ctr = C_SRAW; end
      end
      7'b0110111: begin e.ill = 1'b0; e.b = immu; e.ctr = C_PASSB; end
      7'b0010111: begin e.ill = 1'b0; e.a = pc; e.b = immu; e.ctr = C_ADD; end
      7'b1101111: begin e.ill = 1'b0; e.a = pc; e.b = 64'd4; e.ctr = C_ADD; end
      7'b1100111: begin e.ill = (f3 != 3'd0); e.a = pc; e.b = 64'd4; e.ctr = C_ADD; end
      7'b0000011: begin e.ill = (f3 == 3'd7); e.a = r1; e.b = immi; e.ctr = C_ADD; end
      7'b0100011: begin e.ill = (f3 > 3'd3); e.a = r1; e.b = imms; e.ctr = C_ADD; end
      7'b1100011: begin
        e.a = r1; e.b = r2;
        e.ill = (f3 == 3'd2 || f3 == 3'd3);
        if (f3 == 3'd0 || f3 == 3'd1) e.ctr = C_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.ctr = C_SLT;
        else e.ctr = C_SLTU;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.a = '0; e.b = '0; e.ctr = '0; end
    return e;
  endfunction

  // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    ent_t e;
    bit   in_fire, out_fire;
    @(negedge clk);
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() != 0) begin
      e = q[0];
      chk("out_a", bus.out_a, e.a);
      chk("out_b", bus.out_b, e.b);
      chk("out_pc", bus.out_pc, e.pc);
      chk("out_aluctr", bus.out_aluctr, e.ctr);
      chk("out_illegal", bus.out_illegal, e.ill);
    end
    in_fire  = bus.in_valid && (q.size() < 2);
    out_fire = (q.size() != 0) && bus.out_ready;
    if (flush) q.delete();
    else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(model(bus.in_inst, bus.in_pc, bus.in_rs1, bus.in_rs2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    bus.in_rs1   = r1;
    bus.in_rs2   = r2;
  endtask

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0: return 7'h00;
      1: return 7'h20;
      2: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  begin w[6:0] = 7'b0110011; w[31:25] = pick_f7(); end
      1:  begin w[6:0] = 7'b0111011; w[31:25] = pick_f7(); end
      2:  begin w[6:0] = 7'b0010011; if ($urandom_range(0, 1) == 0) w[31:26] = pick_f7() >> 1; end
      3:  begin w[6:0] = 7'b0011011; w[31:25] = pick_f7(); end
      4:  w[6:0] = 7'b0110111;
      5:  w[6:0] = 7'b0010111;
      6:  w[6:0] = 7'b1101111;
      7:  w[6:0] = 7'b1100111;
      8:  w[6:0] = 7'b0000011;
      9:  w[6:0] = 7'b0100011;
      10: w[6:0] = 7'b1100011;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] I_ADD = 32'h002081B3;

  initial begin
    ent_t m;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);

    // model pins against hand-decoded words
    m = model(32'h402081B3, 64'h0, 64'd5, 64'd7);
    chk("pin_sub", {m.ctr, m.ill}, {C_SUB, 1'b0});
    m = model(32'h4031509B, 64'h0, 64'd0, 64'd0);
    chk("pin_sraiw", {m.b, m.ctr}, {64'd3, 5'b11101});
    m = model(32'h02208033, 64'h0, 64'd9, 64'd9);
    chk("pin_mul", {m.a, m.b, m.ctr, m.ill}, {64'd0, 64'd0, 5'd0, 1'b1});

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_a", bus.out_a, 64'd0);
    chk("rst_out_b", bus.out_b, 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_aluctr", bus.out_aluctr, 5'd0);
    chk("rst_illegal", bus.out_illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed decode cases
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h402081B3, 64'h1000, 64'd5, 64'd7);
    step();
    chk("sub_a", bus.out_a, 64'd5);
    chk("sub_b", bus.out_b, 64'd7);
    chk("sub_ctr", bus.out_aluctr, 5'b01000);
    chk("sub_ill", bus.out_illegal, 1'b0);
    drive(1'b1, 32'h4031509B, 64'h1004, 64'h55, 64'h0);
    step();
    chk("sraiw_ctr", bus.out_aluctr, 5'b11101);
    chk("sraiw_b", bus.out_b, 64'd3);
    drive(1'b1, 32'hFFF00093, 64'h1008, 64'h0, 64'h0);
    step();
    chk("addi_b", bus.out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ctr", bus.out_aluctr, 5'b00000);
    drive(1'b1, 32'h0020E063, 64'h100C, 64'd1, 64'd2);
    step();
    chk("bltu_ctr", bus.out_aluctr, 5'b01010);
    drive(1'b1, 32'h00000000, 64'h1010, 64'd3, 64'd4);
    step();
    chk("ill0_flag", bus.out_illegal, 1'b1);
    chk("ill0_ab", {bus.out_a, bus.out_b, bus.out_aluctr}, {128'd0, 5'd0});
    drive(1'b1, 32'h02208033, 64'h1014, 64'd3, 64'd4);
    step();
    chk("mul_flag", bus.out_illegal, 1'b1);
    chk("mul_ab", {bus.out_a, bus.out_b, bus.out_aluctr}, {128'd0, 5'd0});
    chk("mul_pc", bus.out_pc, 64'h1014);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    step();

    // backpressure: third bundle held off, then 1,2,3 in order
    bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 64'h2000, 64'h11, 64'h1);
    step();
    chk("bp_ready_one", bus.in_ready, 1'b1);
    drive(1'b1, I_ADD, 64'h2004, 64'h22, 64'h1);
    step();
    chk("bp_ready_full", bus.in_ready, 1'b0);
    drive(1'b1, I_ADD, 64'h2008, 64'h33, 64'h1);
    step();
    step();
    chk("bp_hold", bus.out_a, 64'h11);
    bus.out_ready = 1'b1;
    step();
    chk("bp_second", bus.out_a, 64'h22);
    step();
    chk("bp_third", bus.out_a, 64'h33);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    step();
    chk("bp_drained", bus.out_valid, 1'b0);

    // flush from FULL with an incoming bundle
    bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 64'h3000, 64'h44, 64'h1);
    step();
    drive(1'b1, I_ADD, 64'h3004, 64'h55, 64'h1);
    step();
    drive(1'b1, I_ADD, 64'h3008, 64'h66, 64'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ready", bus.in_ready, 1'b1);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    bus.out_ready = 1'b1;
    step();
    step();

    // asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 64'h4000, 64'h77, 64'h1);
    step();
    drive(1'b1, 32'h402081B3, 64'h4004, 64'h88, 64'h1);
    step();
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_ready", bus.in_ready, 1'b1);
    chk("arst_ctr", bus.out_aluctr, 5'd0);
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), gen_inst(), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_alu_issue.md
# ysyx_220066_alu_issue

Issue stage that drives the EX-stage ALU operand/control interface. It accepts a decoded-stage bundle (instruction, PC, register-file read values), generates the 5-bit ALU control word plus both 64-bit operands for RV64I, and presents them through a registered valid/ready pipeline slot. A skid entry lets the input ready be a flop output. It sits between register read and the ALU, and is the producer side of the ALU's `aluctr`/operand contract.

## Interface
- No parameters; XLEN fixed at 64, ILEN at 32.
- Reset is asynchronous and active-low: `rst_n` clears all state immediately, independent of `clk`; all other behaviour is on `clk` rising edge.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous kill of all held and incoming entries
- `in_valid`  in  1  input bundle valid
- `in_ready`  out  1  slot can accept; registered
- `in_inst`  in  32  instruction word
- `in_pc`  in  64  instruction PC
- `in_rs1`, `in_rs2`  in  64 each  register read values
- `out_valid`  out  1  ALU bundle valid
- `out_ready`  in  1  EX consumes bundle
- `out_a`, `out_b`  out  64 each  ALU operands
- `out_aluctr`  out  5  {W, A, op[2:0]}
- `out_pc`  out  64  PC passthrough
- `out_illegal`  out  1  instruction not handled by this unit

## Operation
- ALU control encoding. op: 0 add/sub, 1 sll, 2 slt, 3 pass-B, 4 xor, 5 shift-right, 6 or, 7 and.
- A bit: subtract for op0, unsigned compare for op2, arithmetic shift for op5.
- W bit: 32-bit op with sign-extended result.
- Words: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 01010, PASSB 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, ADDW 10000, SUBW 11000, SLLW 10001, SRLW 10101, SRAW 11101.
- Decode is combinational on inputs; results are stored in the slot at acceptance. Immediates are sign-extended to 64.
- OP (0110011), funct7 0000000/0100000: a=rs1, b=rs2, op from funct3, A=funct7[5] only for sub/sra.
- OP-32 (0111011): add/sub/sll/srl/sra only, W=1.
- OP-IMM (0010011): a=rs1, b=I-imm; slli/srli/srai use shamt = inst[25:20] and require inst[31:26] of 000000, or 010000 for srai.
- OP-IMM-32 (0011011): addiw/slliw/srliw/sraiw; inst[25]=1 is illegal.
- LUI: a=0, b=U-imm, PASSB.
- AUIPC: a=pc, b=U-imm, ADD.
- JAL/JALR: a=pc, b=4, ADD.
- LOAD/STORE: a=rs1, b=I-imm or S-imm, ADD.
- BRANCH: a=rs1, b=rs2. beq/bne use SUB (EX uses zero); blt/bge use SLT; bltu/bgeu use SLTU. funct3 010/011 is illegal.
- Any other opcode or funct field, including M-extension funct7 0000001: out_illegal=1, a=b=0, aluctr=00000. The bundle still flows.

## Timing
- States: EMPTY (no entry), ONE (main entry valid), FULL (main + skid valid).
- out_valid = state≠EMPTY; in_ready = state≠FULL, driven from a register.
- Fire rules: in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- EMPTY → ONE on in fire.
- ONE → FULL on in fire & !out_ready; new entry goes to skid.
- ONE → ONE on in fire & out fire; main is replaced.
- ONE → EMPTY on out fire with no in fire.
- FULL → ONE on out fire; skid moves to main.
- Latency: accepted at edge N, visible on out_* after edge N; out_valid is high in cycle N+1.
- Throughput: one per cycle while out_ready is held high.
- Order is preserved. No entry is dropped or duplicated.
- out_* must not change while out_valid & !out_ready.
- flush has priority over everything: next state EMPTY, input in that cycle discarded, in_ready=1 the next cycle.
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_a/out_b/out_pc 0, out_aluctr 00000, out_illegal 0. Reset asserted mid-transfer discards all entries immediately.

## Test plan
- Reset: assert rst_n=0 between edges while FULL -> out_valid=0, in_ready=1, out_aluctr=00000 immediately; state remains empty after release.
- SUB: inst 0x402081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_a=5, out_b=7, out_aluctr=01000, out_illegal=0.
- SRAIW: inst 0x4031509B -> aluctr=11101, b=3. ADDI x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFFFFFFFFFF, aluctr=00000. BLTU -> 01010.
- Backpressure: out_ready=0, issue 3 back-to-back bundles -> in_ready drops after the 2nd accept and the 3rd is held off. Raise out_ready -> bundles emerge 1,2,3 on consecutive cycles, out_* stable while stalled.
- Flush: state FULL, in_valid=1, flush=1 -> next cycle out_valid=0, in_ready=1, and the incoming bundle never appears.
- Illegal: inst 0x00000000, then MUL 0x02208033 -> out_illegal=1, a=b=0, aluctr=00000 each, one cycle apart.
